pmt_pulse_conditioner: RTL and testbench

// Front end for the PMT photon counter. Brings the asynchronous PMT discriminator output into
// the main_clock domain. Rejects glitches shorter than MIN_HIGH cycles and enforces a
// non-paralyzable dead time. Each accepted photon is tagged with the light-modulation phase
// and queued in a small FIFO; the lock-in counter and waveform stage pop the FIFO via valid/ready.

---
 rtl/pmt_pulse_conditioner.sv | 215 +++++++++++++++++++++
 tb/tb_pmt_pulse_conditioner.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmt_pulse_conditioner.sv
// PMT pulse front end: synchronizer, glitch filter, dead time,
// phase tagging and a small valid/ready event FIFO.
module pmt_pulse_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HIGH    = 2,
  parameter int DEAD_TIME   = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int PHASE_W     = 32
) (
  input  logic               main_clock,
  input  logic               reset,
  input  logic               pmt_in,
  input  logic               enable,
  input  logic [PHASE_W-1:0] phase_in,
  input  logic               in_phase_in,
  input  logic               quadrature_in,
  output logic               event_valid,
  input  logic               event_ready,
  output logic [PHASE_W-1:0] event_phase,
  output logic               event_i,
  output logic               event_q,
  output logic [31:0]        accepted_count,
  output logic [31:0]        glitch_count,
  output logic [31:0]        deadtime_count,
  output logic [31:0]        overflow_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = PHASE_W + 2;
  localparam int CW = 16;

  typedef enum logic [1:0] {
    IDLE,
    QUALIFY,
    DEAD
  } state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   s_d;
  logic                   armed;
  logic                   rise;
  logic [CW-1:0]          fill;

  always_ff @(posedge main_clock or posedge reset) begin
    if (reset) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pmt_in};
      s_d  <= s;
    end
  end

  assign s = sync[SYNC_STAGES-1];

  // After reset, wait for the chain to refill and see a low level,
  // so a pulse already high at release cannot fake a rising edge.
  always_ff @(posedge main_clock or posedge reset) begin
    if (reset) begin
      fill  <= '0;
      armed <= 1'b0;
    end else if (!armed) begin
      if (fill != CW'(SYNC_STAGES)) begin
        fill <= fill + CW'(1);
      end else if (!s) begin
        armed <= 1'b1;
      end
    end
  end

  assign rise = armed & s & ~s_d;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] high_cnt;
  logic [CW-1:0] high_nx;
  logic [CW-1:0] dead_cnt;
  logic [CW-1:0] dead_nx;
  logic [TW-1:0] tag;
  logic [TW-1:0] tag_nx;
  logic [TW-1:0] push_tag;
  logic          qualify;
  logic          glitch;
  logic          dead_hit;

  always_ff @(posedge main_clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      high_cnt <= '0;
      dead_cnt <= '0;
      tag      <= '0;
    end else begin
      state    <= state_nx;
      high_cnt <= high_nx;
      dead_cnt <= dead_nx;
      tag      <= tag_nx;
    end
  end

  always_comb begin
    state_nx = state;
    high_nx  = high_cnt;
    dead_nx  = dead_cnt;
    tag_nx   = tag;
    push_tag = tag;
    qualify  = 1'b0;
    glitch   = 1'b0;
    dead_hit = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise && enable) begin
          tag_nx  = {phase_in, in_phase_in, quadrature_in};
          high_nx = CW'(1);
          if (MIN_HIGH == 1) begin
            qualify  = 1'b1;
            push_tag = tag_nx;
            dead_nx  = '0;
            state_nx = DEAD;
          end else begin
            state_nx = QUALIFY;
          end
        end
      end
      QUALIFY: begin
        if (s) begin
          if (high_cnt + CW'(1) >= CW'(MIN_HIGH)) begin
            qualify  = 1'b1;
            dead_nx  = '0;
            state_nx = DEAD;
          end else begin
            high_nx = high_cnt + CW'(1);
          end
        end else begin
          glitch   = 1'b1;
          state_nx = IDLE;
        end
      end
      DEAD: begin
        dead_hit = rise;
        if (dead_cnt == CW'(DEAD_TIME - 1)) begin
          state_nx = IDLE;
        end else begin
          dead_nx = dead_cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  logic [TW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign pop  = event_valid & event_ready;
  // A pop in the qualify cycle frees the slot the new tag needs.
  assign push = qualify & (~full | pop);
  assign drop = qualify & full & ~pop;

  always_ff @(posedge main_clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_tag;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign event_valid = count != '0;
  assign {event_phase, event_i, event_q} = mem[rd_ptr];

  always_ff @(posedge main_clock or posedge reset) begin
    if (reset) begin
      accepted_count <= '0;
      glitch_count   <= '0;
      deadtime_count <= '0;
      overflow_count <= '0;
    end else begin
      if (push && accepted_count != '1) begin
        accepted_count <= accepted_count + 32'd1;
      end
      if (glitch && glitch_count != '1) begin
        glitch_count <= glitch_count + 32'd1;
      end
      if (dead_hit && deadtime_count != '1) begin
        deadtime_count <= deadtime_count + 32'd1;
      end
      if (drop && overflow_count != '1) begin
        overflow_count <= overflow_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pmt_pulse_conditioner.sv
// Bench for pmt_pulse_conditioner: directed scenarios plus random
// pulse trains against an event-level reference model.
module tb_pmt_pulse_conditioner;

  localparam int SYNC  = 2;
  localparam int MINH  = 2;
  localparam int DEAD  = 8;
  localparam int DEPTH = 4;
  localparam int MAXN  = 512;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pmt_in = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] phase_in = '0;
  logic        in_phase_in = 1'b0;
  logic        quadrature_in = 1'b0;
  logic        event_valid;
  logic        event_ready = 1'b0;
  logic [31:0] event_phase;
  logic        event_i;
  logic        event_q;
  logic [31:0] accepted_count;
  logic [31:0] glitch_count;
  logic [31:0] deadtime_count;
  logic [31:0] overflow_count;

  pmt_pulse_conditioner #(
    .SYNC_STAGES(SYNC),
    .MIN_HIGH(MINH),
    .DEAD_TIME(DEAD),
    .FIFO_DEPTH(DEPTH),
    .PHASE_W(32)
  ) dut (
    .main_clock(clk),
    .reset(reset),
    .pmt_in(pmt_in),
    .enable(enable),
    .phase_in(phase_in),
    .in_phase_in(in_phase_in),
    .quadrature_in(quadrature_in),
    .event_valid(event_valid),
    .event_ready(event_ready),
    .event_phase(event_phase),
    .event_i(event_i),
    .event_q(event_q),
    .accepted_count(accepted_count),
    .glitch_count(glitch_count),
    .deadtime_count(deadtime_count),
    .overflow_count(overflow_count)
  );

  always #5 clk = ~clk;

  bit          pmt_a [MAXN];
  bit          en_a  [MAXN];
  bit          rdy_a [MAXN];
  bit          ia    [MAXN];
  bit          qa    [MAXN];
  logic [31:0] ph_a  [MAXN];
  bit          obs_v [MAXN];
  logic [33:0] obs_h [MAXN];
  bit          exp_v [MAXN];
  logic [33:0] exp_h [MAXN];
  logic [31:0] oa, og, od, oo;
  int          ea, eg, ed, eo;
  int          vec = 0;
  int          err = 0;

  task automatic clear_stim();
    for (int t = 0; t < MAXN; t++) begin
      pmt_a[t] = 1'b0;
      en_a[t]  = 1'b1;
      rdy_a[t] = 1'b1;
      ph_a[t]  = 32'(t + 10);
      ia[t]    = 1'($urandom);
      qa[t]    = 1'($urandom);
    end
  endtask

  task automatic pulse(input int start, input int len);
    for (int t = start; t < start + len && t < MAXN; t++) begin
      pmt_a[t] = 1'b1;
    end
  endtask

  function automatic bit sv(input int t, input bit pre);
    int j;
    j = t - SYNC;
    if (j < 0) return pre;
    if (j >= MAXN) return 1'b0;
    return pmt_a[j];
  endfunction

  // Event-level model: finds each rising edge of the synchronized
  // level, measures the run length, and applies dead time and the FIFO.
  task automatic model(input int n, input bit pre);
    bit          qv [MAXN];
    logic [33:0] qt [MAXN];
    logic [33:0] fq [$];
    int busy, dfrom, len, q;
    bit e, v;
    busy = 0;
    dfrom = 0;
    ea = 0; eg = 0; ed = 0; eo = 0;
    fq = {};
    for (int t = 0; t < MAXN; t++) qv[t] = 1'b0;
    for (int t = 0; t < n; t++) begin
      e = sv(t, pre) && !sv(t - 1, pre);
      if (e && t >= busy) begin
        if (en_a[t]) begin
          len = 0;
          while (len < 64 && sv(t + len, pre)) len++;
          if (len >= MINH) begin
            q = t + MINH - 1;
            if (q < MAXN) begin
              qv[q] = 1'b1;
              qt[q] = {ph_a[t], ia[t], qa[t]};
            end
            dfrom = q + 1;
            busy  = q + DEAD + 1;
          end else begin
            if (t + len < n) eg++;
            busy = t + len + 1;
          end
        end
      end else if (e && t >= dfrom) begin
        ed++;
      end
    end
    for (int t = 0; t < n; t++) begin
      v = fq.size() > 0;
      exp_v[t] = v;
      exp_h[t] = v ? fq[0] : 34'd0;
      if (v && rdy_a[t]) void'(fq.pop_front());
      if (qv[t]) begin
        if (fq.size() < DEPTH) begin
          fq.push_back(qt[t]);
          ea++;
        end else begin
          eo++;
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int t = 0; t < n; t++) begin
      @(posedge clk);
      #1;
      pmt_in        = pmt_a[t];
      enable        = en_a[t];
      event_ready   = rdy_a[t];
      phase_in      = ph_a[t];
      in_phase_in   = ia[t];
      quadrature_in = qa[t];
      #3;
      obs_v[t] = event_valid;
      obs_h[t] = {event_phase, event_i, event_q};
    end
    @(posedge clk);
    #1;
    oa = accepted_count;
    og = glitch_count;
    od = deadtime_count;
    oo = overflow_count;
  endtask

  task automatic apply_reset(input bit level);
    #1;
    reset       = 1'b1;
    pmt_in      = level;
    enable      = 1'b1;
    event_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    pmt_in = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    vec++;
    if (event_valid !== 1'b0) begin
      err++;
      $display("FAIL reset_valid got=%b want=0", event_valid);
    end
    vec++;
    if ({event_phase, event_i, event_q} !== 34'd0) begin
      err++;
      $display("FAIL reset_head got=%h want=0", {event_phase, event_i, event_q});
    end
    vec++;
    if ({accepted_count, glitch_count, deadtime_count, overflow_count} !== 128'd0) begin
      err++;
      $display("FAIL reset_counts got=%h want=0",
               {accepted_count, glitch_count, deadtime_count, overflow_count});
    end
    apply_reset(1'b0);
  endtask

  task automatic test_single_pulse();
    int nv;
    apply_reset(1'b0);
    clear_stim();
    pulse(0, 5);
    model(30, 1'b0);
    run(30);
    nv = 0;
    for (int t = 0; t < 30; t++) begin
      nv += int'(obs_v[t]);
      vec++;
      if (obs_v[t] !== exp_v[t] || (exp_v[t] && obs_h[t] !== exp_h[t])) begin
        err++;
        $display("FAIL single t=%0d got v=%b h=%h want v=%b h=%h",
                 t, obs_v[t], obs_h[t], exp_v[t], exp_h[t]);
      end
    end
    vec++;
    if (obs_v[4] !== 1'b1 || obs_h[4][33:2] !== 32'd12 || nv != 1) begin
      err++;
      $display("FAIL single_tag got v=%b phase=%0d nvalid=%0d want v=1 phase=12 nvalid=1",
               obs_v[4], obs_h[4][33:2], nv);
    end
    vec++;
    if ({oa, og, od, oo} !== {32'd1, 32'd0, 32'd0, 32'd0}) begin
      err++;
      $display("FAIL single_counts got=%0d/%0d/%0d/%0d want=1/0/0/0", oa, og, od, oo);
    end
  endtask

  task automatic test_glitch();
    apply_reset(1'b0);
    clear_stim();
    pulse(0, 1);
    model(20, 1'b0);
    run(20);
    for (int t = 0; t < 20; t++) begin
      vec++;
      if (obs_v[t] !== 1'b0) begin
        err++;
        $display("FAIL glitch t=%0d got v=%b want v=0", t, obs_v[t]);
      end
    end
    vec++;
    if ({oa, og, od, oo} !== {32'd0, 32'd1, 32'd0, 32'd0} || eg != 1) begin
      err++;
      $display("FAIL glitch_counts got=%0d/%0d/%0d/%0d want=0/1/0/0", oa, og, od, oo);
    end
  endtask

  task automatic test_dead_time();
    apply_reset(1'b0);
    clear_stim();
    pulse(0, 3);
    pulse(4, 3);
    pulse(12, 3);
    model(40, 1'b0);
    run(40);
    for (int t = 0; t < 40; t++) begin
      vec++;
      if (obs_v[t] !== exp_v[t] || (exp_v[t] && obs_h[t] !== exp_h[t])) begin
        err++;
        $display("FAIL dead t=%0d got v=%b h=%h want v=%b h=%h",
                 t, obs_v[t], obs_h[t], exp_v[t], exp_h[t]);
      end
    end
    vec++;
    if ({oa, og, od, oo} !== {32'd2, 32'd0, 32'd1, 32'd0}) begin
      err++;
      $display("FAIL dead_counts got=%0d/%0d/%0d/%0d want=2/0/1/0", oa, og, od, oo);
    end
  endtask

  task automatic test_overflow();
    apply_reset(1'b0);
    clear_stim();
    for (int p = 0; p < 6; p++) pulse(p * 16, 3);
    for (int t = 0; t < 100; t++) rdy_a[t] = 1'b0;
    model(120, 1'b0);
    run(120);
    for (int t = 0; t < 120; t++) begin
      vec++;
      if (obs_v[t] !== exp_v[t] || (exp_v[t] && obs_h[t] !== exp_h[t])) begin
        err++;
        $display("FAIL overflow t=%0d got v=%b h=%h want v=%b h=%h",
                 t, obs_v[t], obs_h[t], exp_v[t], exp_h[t]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      vec++;
      if (obs_v[100 + k] !== 1'b1 || obs_h[100 + k][33:2] !== 32'(12 + 16 * k)) begin
        err++;
        $display("FAIL overflow_order pop=%0d got v=%b phase=%0d want v=1 phase=%0d",
                 k, obs_v[100 + k], obs_h[100 + k][33:2], 12 + 16 * k);
      end
    end
    vec++;
    if ({oa, oo, obs_v[104]} !== {32'd4, 32'd2, 1'b0}) begin
      err++;
      $display("FAIL overflow_counts got acc=%0d ovf=%0d v=%b want acc=4 ovf=2 v=0",
               oa, oo, obs_v[104]);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset(1'b0);
    clear_stim();
    for (int p = 0; p < 5; p++) pulse(p * 16, 3);
    for (int t = 0; t < 90; t++) rdy_a[t] = (t == 67);
    model(90, 1'b0);
    run(90);
    for (int t = 0; t < 90; t++) begin
      vec++;
      if (obs_v[t] !== exp_v[t] || (exp_v[t] && obs_h[t] !== exp_h[t])) begin
        err++;
        $display("FAIL simul t=%0d got v=%b h=%h want v=%b h=%h",
                 t, obs_v[t], obs_h[t], exp_v[t], exp_h[t]);
      end
    end
    vec++;
    if ({oa, oo} !== {32'd5, 32'd0} || obs_v[89] !== 1'b1 ||
        obs_h[89][33:2] !== 32'd28) begin
      err++;
      $display("FAIL simul_counts got acc=%0d ovf=%0d v=%b head=%0d want acc=5 ovf=0 v=1 head=28",
               oa, oo, obs_v[89], obs_h[89][33:2]);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset(1'b0);
    clear_stim();
    for (int p = 0; p < 3; p++) pulse(p * 16, 3);
    pulse(48, 20);
    for (int t = 0; t < MAXN; t++) rdy_a[t] = 1'b0;
    model(51, 1'b0);
    run(51);
    vec++;
    if (oa !== 32'd3 || ea != 3 || obs_v[50] !== 1'b1) begin
      err++;
      $display("FAIL mid_prefill got acc=%0d v=%b want acc=3 v=1", oa, obs_v[50]);
    end
    #1;
    reset = 1'b1;
    #1;
    vec++;
    if ({event_valid, event_phase, event_i, event_q, accepted_count} !== 67'd0) begin
      err++;
      $display("FAIL mid_async got v=%b head=%h acc=%0d want all 0",
               event_valid, {event_phase, event_i, event_q}, accepted_count);
    end
    apply_reset(1'b1);
    clear_stim();
    pulse(0, 10);
    pulse(13, 5);
    model(40, 1'b1);
    run(40);
    for (int t = 0; t < 40; t++) begin
      vec++;
      if (obs_v[t] !== exp_v[t] || (exp_v[t] && obs_h[t] !== exp_h[t])) begin
        err++;
        $display("FAIL mid t=%0d got v=%b h=%h want v=%b h=%h",
                 t, obs_v[t], obs_h[t], exp_v[t], exp_h[t]);
      end
    end
    vec++;
    if (oa !== 32'd1 || obs_v[16] !== 1'b0 || obs_v[17] !== 1'b1 ||
        obs_h[17][33:2] !== 32'd25) begin
      err++;
      $display("FAIL mid_rearm got acc=%0d v16=%b v17=%b phase=%0d want acc=1 v16=0 v17=1 phase=25",
               oa, obs_v[16], obs_v[17], obs_h[17][33:2]);
    end
  endtask

  task automatic test_random();
    int t, gap, len;
    for (int r = 0; r < 4; r++) begin
      apply_reset(1'b0);
      clear_stim();
      for (int k = 0; k < MAXN; k++) begin
        en_a[k]  = $urandom_range(0, 9) != 0;
        rdy_a[k] = $urandom_range(0, 9) < 6;
        ph_a[k]  = $urandom;
      end
      t = 0;
      while (t < 270) begin
        gap = int'($urandom_range(0, 14));
        len = int'($urandom_range(1, 5));
        pulse(t + gap, len);
        t += gap + len + 1;
      end
      model(300, 1'b0);
      run(300);
      for (int k = 0; k < 300; k++) begin
        vec++;
        if (obs_v[k] !== exp_v[k] || (exp_v[k] && obs_h[k] !== exp_h[k])) begin
          err++;
          $display("FAIL random r=%0d t=%0d got v=%b h=%h want v=%b h=%h",
                   r, k, obs_v[k], obs_h[k], exp_v[k], exp_h[k]);
        end
      end
      vec++;
      if ({oa, og, od, oo} !== {32'(ea), 32'(eg), 32'(ed), 32'(eo)}) begin
        err++;
        $display("FAIL random_counts r=%0d got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d",
                 r, oa, og, od, oo, ea, eg, ed, eo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_glitch();
    test_dead_time();
    test_overflow();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
